// File: rtl/repeater_queue_if.sv
// ---------------------------------------------------------------------------
// repeater_queue_if
// Handshake bundle between a producer/consumer pair and repeater_queue.
//
// Parameters:
//   DATA_W - payload width
//   CNT_W  - repeat count width
//
// Signals:
//   io_enq_valid / io_enq_ready / io_enq_bits / io_enq_count : enqueue side
//   io_deq_valid / io_deq_ready / io_deq_bits / io_deq_last  : dequeue side
//   io_full / io_empty                                       : occupancy flags
//   io_abort (only with REPEATER_QUEUE_ABORT_EN)             : drop head entry
//
// Modports:
//   master - the environment (producer + consumer) driving the queue
//   slave  - the repeater_queue itself
// ---------------------------------------------------------------------------
interface repeater_queue_if #(
   parameter int DATA_W = 40,
   parameter int CNT_W  = 4
);
   logic              io_enq_valid;
   logic              io_enq_ready;
   logic [DATA_W-1:0] io_enq_bits;
   logic [CNT_W-1:0]  io_enq_count;
   logic              io_deq_valid;
   logic              io_deq_ready;
   logic [DATA_W-1:0] io_deq_bits;
   logic              io_deq_last;
   logic              io_full;
   logic              io_empty;
`ifdef REPEATER_QUEUE_ABORT_EN
   logic              io_abort;

   modport master (
      output io_enq_valid, io_enq_bits, io_enq_count, io_deq_ready, io_abort,
      input  io_enq_ready, io_deq_valid, io_deq_bits, io_deq_last, io_full, io_empty
   );

   modport slave (
      input  io_enq_valid, io_enq_bits, io_enq_count, io_deq_ready, io_abort,
      output io_enq_ready, io_deq_valid, io_deq_bits, io_deq_last, io_full, io_empty
   );
`else
   modport master (
      output io_enq_valid, io_enq_bits, io_enq_count, io_deq_ready,
      input  io_enq_ready, io_deq_valid, io_deq_bits, io_deq_last, io_full, io_empty
   );

   modport slave (
      input  io_enq_valid, io_enq_bits, io_enq_count, io_deq_ready,
      output io_enq_ready, io_deq_valid, io_deq_bits, io_deq_last, io_full, io_empty
   );
`endif
endinterface

// File: rtl/repeater_queue.sv
// ---------------------------------------------------------------------------
// repeater_queue
// FIFO of words where each word is emitted (count + 1) times on the dequeue
// side before the next word is presented. When the queue holds nothing, an
// offered word flows straight through in the same cycle; only the repeats
// that are still owed get stored.
//
// Parameters:
//   DATA_W - payload width (default 40)
//   DEPTH  - number of stored entries, 1..16 (default 2)
//   CNT_W  - repeat count width (default 4)
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high reset
//   io    - repeater_queue_if.slave handshake bundle
//
// Optional feature:
//   REPEATER_QUEUE_ABORT_EN - when defined, io.io_abort blocks both
//   handshakes and drops the stored head entry at the clock edge.
// ---------------------------------------------------------------------------
module repeater_queue #(
   parameter int DATA_W = 40,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 4
) (
   input logic              clock,
   input logic              reset,
   repeater_queue_if.slave  io
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_bits [DEPTH];
   logic [CNT_W-1:0]  mem_rem  [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [OCC_W-1:0]  occ;

   logic              abort;
   logic              is_empty;
   logic              is_full;
   logic              enq_fire;
   logic              deq_fire;
   logic              flow_fire;
   logic              store;
   logic              pop;
   logic              repeat_dec;
   logic [CNT_W-1:0]  head_rem;
   logic [CNT_W-1:0]  store_rem;

`ifdef REPEATER_QUEUE_ABORT_EN
   assign abort = io.io_abort;
`else
   assign abort = 1'b0;
`endif

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Output and handshake decode. While reset is asserted the queue is
   // presented as empty so the outputs already show the post-reset view.
   // A word whose first beat flows through is stored with one repeat less;
   // a single-beat flow-through word is never stored at all.
   always_comb begin
      is_empty   = reset || (occ == '0);
      is_full    = !reset && (occ == OCC_W'(DEPTH));
      head_rem   = mem_rem[head];

      io.io_empty     = is_empty;
      io.io_full      = is_full;
      io.io_enq_ready = !is_full && !abort;

      if (is_empty) begin
         io.io_deq_valid = io.io_enq_valid && !abort;
         io.io_deq_bits  = io.io_enq_bits;
         io.io_deq_last  = (io.io_enq_count == '0);
      end else begin
         io.io_deq_valid = !abort;
         io.io_deq_bits  = mem_bits[head];
         io.io_deq_last  = (head_rem == '0);
      end

      enq_fire   = io.io_enq_valid && io.io_enq_ready;
      deq_fire   = io.io_deq_valid && io.io_deq_ready;
      flow_fire  = is_empty && deq_fire;
      store      = enq_fire && !(flow_fire && (io.io_enq_count == '0));
      store_rem  = flow_fire ? (io.io_enq_count - 1'b1) : io.io_enq_count;
      repeat_dec = !is_empty && deq_fire && (head_rem != '0);
      pop        = !is_empty && ((deq_fire && (head_rem == '0)) || abort);
   end

   // Payload storage carries no reset; validity is governed by occupancy.
   always_ff @(posedge clock) begin
      if (store) begin
         mem_bits[tail] <= io.io_enq_bits;
      end
   end

   // Pointer, occupancy and repeat-counter state. A store and a decrement
   // never target the same slot: storing with a non-empty queue implies
   // it is not full, so tail differs from head.
   always_ff @(posedge clock) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_rem[i] <= '0;
         end
      end else begin
         if (store) begin
            mem_rem[tail] <= store_rem;
            tail          <= next_ptr(tail);
         end
         if (repeat_dec) begin
            mem_rem[head] <= head_rem - 1'b1;
         end
         if (pop) begin
            head <= next_ptr(head);
         end
         occ <= occ + OCC_W'(store) - OCC_W'(pop);
      end
   end
endmodule

// File: doc/repeater_queue.md
REPEATER_QUEUE -- requirements
Module: repeater_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 40: width of the payload word.
REQ-002 SHALL have parameter DEPTH, default 2, legal range 1..16: number of stored entries.
REQ-003 SHALL have parameter CNT_W, default 4: width of the repeat count.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port io_enq_valid, input, 1 bit: the producer offers a word.
REQ-007 SHALL have port io_enq_ready, output, 1 bit: the block accepts the offered word.
REQ-008 SHALL have port io_enq_bits, input, DATA_W bits: the payload.
REQ-009 SHALL have port io_enq_count, input, CNT_W bits: the number of extra repeats, so the word is emitted count+1 times.
REQ-010 SHALL have port io_deq_valid, output, 1 bit: an output beat is offered.
REQ-011 SHALL have port io_deq_ready, input, 1 bit: the consumer takes the beat.
REQ-012 SHALL have port io_deq_bits, output, DATA_W bits: the output payload.
REQ-013 SHALL have port io_deq_last, output, 1 bit: the current beat is the final repeat of its word.
REQ-014 SHALL have port io_full, output, 1 bit: occupancy equals DEPTH.
REQ-015 SHALL have port io_empty, output, 1 bit: occupancy equals 0.

Function
REQ-016 SHALL hold a circular buffer of DEPTH entries, each {bits, remaining}, with head/tail pointers that wrap at DEPTH and an occupancy counter of width clog2(DEPTH+1).
REQ-017 SHALL drive io_enq_ready = ~io_full; there is no same-cycle bypass when full, even if the head is popping.
REQ-018 SHALL, when empty, flow through combinationally: deq_valid=enq_valid, deq_bits=enq_bits, deq_last=(enq_count==0); latency zero.
REQ-019 SHALL, when not empty, drive deq_valid=1, deq_bits=head.bits and deq_last=(head.remaining==0).
REQ-020 SHALL store nothing on a flow-through beat where enq fires, deq fires and enq_count==0.
REQ-021 SHALL, on any other enq fire, write the word at tail with remaining = enq_count-1 if it flow-through fired this cycle, else enq_count, then advance tail.
REQ-022 SHALL, on a deq fire from a stored head with remaining>0, decrement remaining and leave the pointers unchanged.
REQ-023 SHALL, on a deq fire from a stored head with remaining==0, pop: advance head and decrement occupancy.
REQ-024 SHALL, on simultaneous push and pop, leave occupancy unchanged, including when DEPTH=1.
REQ-025 SHALL treat enq_count all-ones as 2^CNT_W total beats with no overflow, because remaining is CNT_W bits.
REQ-026 SHALL keep output order strictly FIFO; a word is never interleaved with its successor.

Reset
REQ-027 SHALL, under reset, clear head, tail, occupancy and every remaining field to 0; payload storage is not reset.
REQ-028 SHALL, during and in the cycle after reset, drive io_empty=1, io_full=0, io_enq_ready=1, and io_deq_valid equal to io_enq_valid (flow-through).
REQ-029 SHALL, on reset asserted mid-repeat, discard all stored words and their remaining repeats at that edge.

Configuration
REQ-030 SHALL, with macro REPEATER_QUEUE_ABORT_EN defined, add port io_abort, input, 1 bit.
REQ-031 SHALL, while io_abort=1, force io_deq_valid=0 and io_enq_ready=0, and pop the head entry at the edge if not empty.
REQ-032 SHALL, without REPEATER_QUEUE_ABORT_EN, omit io_abort entirely, with behaviour identical to abort tied 0.

Verification
REQ-033 SHALL cover: empty, enq word 0xA5 count=0, deq_ready=1 -> same-cycle deq 0xA5 with last=1, io_empty stays 1.
REQ-034 SHALL cover: enq 0x11 count=2, deq_ready=1 -> three beats 0x11 on consecutive cycles, last only on the third, then empty.
REQ-035 SHALL cover: DEPTH=2, deq_ready=0, enq 0x1 count=0 and 0x2 count=0 -> full=1 and enq_ready=0; raise ready -> 0x1 then 0x2.
REQ-036 SHALL cover: full, with head on its last repeat popping while enq_valid=1 -> enq_ready=0 that cycle, accepted the next cycle; order preserved.
REQ-037 SHALL cover: CNT_W=2, count=3, ready=1 -> exactly 4 beats, no wrap to zero repeats.
REQ-038 SHALL cover: with ABORT_EN, abort during the second of 5 repeats -> head dropped, next word presented the following cycle.
